// File: rtl/button_event_ctrl.sv
// button_event_ctrl: N-channel push-button synchroniser, debouncer and edge-event FIFO.
// Optional macro BTN_RELEASE_EVENTS_EN: also queue release events (kind=0).
module button_event_ctrl #(
   parameter int NUM_BTNS        = 4,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int FIFO_DEPTH      = 8,
   parameter int ACTIVE_LOW      = 1,
   localparam int IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1,
   localparam int PTR_W = $clog2(FIFO_DEPTH),
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   input  logic                rd_en,
   input  logic                clr_overflow,
   output logic [IDX_W:0]      event_data,
   output logic                event_valid,
   output logic [PTR_W:0]      event_count,
   output logic [NUM_BTNS-1:0] btn_state,
   output logic                overflow
);

   localparam logic [NUM_BTNS-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [NUM_BTNS-1:0] sync_q1, sync_q2, pressed;
   logic [CNT_W-1:0]    db_cnt [NUM_BTNS];
   logic [NUM_BTNS-1:0] db_done;
   logic [NUM_BTNS-1:0] press_pend, grant_press;
`ifdef BTN_RELEASE_EVENTS_EN
   logic [NUM_BTNS-1:0] rel_pend, grant_rel;
`endif
   logic                req, ev_kind;
   logic [IDX_W-1:0]    ev_idx;
   logic [IDX_W:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic                full, do_rd, do_wr, drop;

   // Synchronisers reset to the released pad level so no phantom press follows reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= IDLE_LVL;
         sync_q2 <= IDLE_LVL;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   assign pressed = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

   // NOTE: every always_comb output gets a default before any conditional, so no latch is inferred.
   always_comb begin
      db_done = '0;
      for (int i = 0; i < NUM_BTNS; i++)
         db_done[i] = (pressed[i] != btn_state[i]) && (db_cnt[i] == CNT_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
         btn_state <= '0;
      end else begin
         for (int i = 0; i < NUM_BTNS; i++) begin
            if (pressed[i] == btn_state[i] || db_done[i]) db_cnt[i] <= '0;
            else                                          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
         end
         btn_state <= btn_state ^ db_done;
      end
   end

   // Lowest channel wins; within a channel a press outranks a release.
   always_comb begin
      req         = 1'b0;
      ev_kind     = 1'b1;
      ev_idx      = '0;
      grant_press = '0;
`ifdef BTN_RELEASE_EVENTS_EN
      grant_rel   = '0;
`endif
      for (int i = 0; i < NUM_BTNS; i++) begin
         if (!req) begin
            if (press_pend[i]) begin
               req            = 1'b1;
               ev_idx         = IDX_W'(i);
               grant_press[i] = 1'b1;
            end
`ifdef BTN_RELEASE_EVENTS_EN
            else if (rel_pend[i]) begin
               req          = 1'b1;
               ev_kind      = 1'b0;
               ev_idx       = IDX_W'(i);
               grant_rel[i] = 1'b1;
            end
`endif
         end
      end
   end

   // A serviced flag clears whether the event was stored or dropped; a fresh edge wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         press_pend <= '0;
`ifdef BTN_RELEASE_EVENTS_EN
         rel_pend   <= '0;
`endif
      end else begin
         press_pend <= (press_pend & ~grant_press) | (db_done & pressed);
`ifdef BTN_RELEASE_EVENTS_EN
         rel_pend   <= (rel_pend & ~grant_rel) | (db_done & ~pressed);
`endif
      end
   end

   assign full        = (event_count == FULL_CNT);
   assign event_valid = (event_count != '0);
   assign do_rd       = rd_en && event_valid;
   assign do_wr       = req && (!full || do_rd);
   assign drop        = req && full && !do_rd;
   assign event_data  = event_valid ? fifo_mem[rd_ptr] : '0;

   // NOTE: storage is not reset; entries are only visible once counted, so reset cost is avoided.
   always_ff @(posedge clk) begin
      if (do_wr) fifo_mem[wr_ptr] <= {ev_kind, ev_idx};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         event_count <= '0;
         overflow    <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   event_count <= event_count + (PTR_W + 1)'(1);
            2'b01:   event_count <= event_count - (PTR_W + 1)'(1);
            default: event_count <= event_count;
         endcase
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)              overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: window-stability/queue model plus directed literals.
// Build with BTN_RELEASE_EVENTS_EN defined to exercise release events.
module tb_button_event_ctrl;

   localparam int NB = 4;
   localparam int DB = 4;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_in = 4'hF;
   logic       rd_en = 1'b0;
   logic       clr_overflow = 1'b0;
   logic [2:0] event_data;
   logic       event_valid;
   logic [2:0] event_count;
   logic [3:0] btn_state;
   logic       overflow;

   int n_vec  = 0;
   int n_miss = 0;

   button_event_ctrl #(
      .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .rd_en(rd_en),
      .clr_overflow(clr_overflow), .event_data(event_data), .event_valid(event_valid),
      .event_count(event_count), .btn_state(btn_state), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a level is accepted once the synchronised input (two samples late) has held the
   // opposite value for DB consecutive clocks; events go through a queue of depth FD.
   bit raw_h   [NB][DB+2];
   bit m_state [NB];
   bit m_pp    [NB];
   bit m_pr    [NB];
   int m_q[$];
   bit m_ovf;

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         for (int k = 0; k < DB + 2; k++) raw_h[i][k] = 1'b0;
         m_state[i] = 1'b0;
         m_pp[i]    = 1'b0;
         m_pr[i]    = 1'b0;
      end
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      int sel = -1;
      bit sel_rel = 1'b0;
      bit stable;
      for (int i = 0; i < NB && sel < 0; i++) begin
         if (m_pp[i]) sel = i;
         else if (m_pr[i]) begin sel = i; sel_rel = 1'b1; end
      end
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (clr_overflow) m_ovf = 1'b0;
      if (sel >= 0) begin
         if (m_q.size() < FD) m_q.push_back(sel_rel ? sel : 4 + sel);
         else                 m_ovf = 1'b1;
         if (sel_rel) m_pr[sel] = 1'b0;
         else         m_pp[sel] = 1'b0;
      end
      for (int i = 0; i < NB; i++) begin
         for (int k = DB + 1; k > 0; k--) raw_h[i][k] = raw_h[i][k-1];
         raw_h[i][0] = ~btn_in[i];
         stable = 1'b1;
         for (int k = 2; k <= DB + 1; k++)
            if (raw_h[i][k] == m_state[i]) stable = 1'b0;
         if (stable) begin
            m_state[i] = ~m_state[i];
            if (m_state[i]) m_pp[i] = 1'b1;
`ifdef BTN_RELEASE_EVENTS_EN
            else            m_pr[i] = 1'b1;
`endif
         end
      end
   endtask

   always @(posedge clk) begin
      logic [3:0] exp_state;
      if (reset) model_reset();
      else       model_step();
      #1;
      for (int i = 0; i < NB; i++) exp_state[i] = m_state[i];
      check("btn_state",   btn_state,   exp_state);
      check("event_count", event_count, m_q.size());
      check("event_valid", event_valid, m_q.size() != 0);
      check("event_data",  event_data,  (m_q.size() != 0) ? m_q[0] : 0);
      check("overflow",    overflow,    m_ovf);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 2 * FD && event_valid; k++) begin
         rd_en = 1'b1;
         tick(1);
      end
      rd_en = 1'b0;
      check("drain_empty", event_valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      tick(3);
      reset = 1'b0;
      check("rst_state", btn_state, 4'b0000);
      check("rst_valid", event_valid, 1'b0);
      check("rst_count", event_count, 3'd0);
      check("rst_ovf",   overflow, 1'b0);
      check("rst_data",  event_data, 3'b000);

      // Clean press on channel 2: accepted on the sixth clock.
      btn_in = 4'b1011;
      tick(5);
      check("press2_early", btn_state, 4'b0000);
      tick(1);
      check("press2_state", btn_state, 4'b0100);
      check("press2_nyvalid", event_valid, 1'b0);
      tick(1);
      check("press2_valid", event_valid, 1'b1);
      check("press2_data",  event_data, 3'b110);
      check("press2_count", event_count, 3'd1);
      pop1();
      check("press2_popped", event_count, 3'd0);
      btn_in = 4'hF;
      tick(10);
      drain();

      // Bouncing channel 1 never holds long enough.
      for (int k = 0; k < 10; k++) begin
         btn_in[1] = ~btn_in[1];
         tick(2);
      end
      tick(10);
      check("bounce_state", btn_state, 4'b0000);
      check("bounce_count", event_count, 3'd0);

      // Channels 0 and 3 together: lower index queued first.
      btn_in = 4'b0110;
      tick(6);
      check("dual_state", btn_state, 4'b1001);
      tick(1);
      check("dual_cnt1",  event_count, 3'd1);
      check("dual_head1", event_data, 3'b100);
      tick(1);
      check("dual_cnt2",  event_count, 3'd2);
      pop1();
      check("dual_head2", event_data, 3'b111);
      pop1();
      check("dual_empty", event_count, 3'd0);
      btn_in = 4'hF;
      tick(10);
      drain();

      // Fill, then overflow with a fifth press.
      btn_in = 4'b0000;
      tick(10);
      check("fill_count", event_count, 3'd4);
      check("fill_ovf",   overflow, 1'b0);
      btn_in = 4'hF;
      tick(10);
      btn_in = 4'b1110;
      tick(10);
      check("ovf_count", event_count, 3'd4);
      check("ovf_flag",  overflow, 1'b1);
      rd_en = 1'b1;
      clr_overflow = 1'b1;
      tick(1);
      rd_en = 1'b0;
      clr_overflow = 1'b0;
      check("clr_count", event_count, 3'd3);
      check("clr_ovf",   overflow, 1'b0);
      check("clr_head",  event_data, 3'b101);
      rd_en = 1'b1;
      tick(4);
      rd_en = 1'b0;
      check("empty_rd_count", event_count, 3'd0);
      check("empty_rd_valid", event_valid, 1'b0);
      check("empty_rd_data",  event_data, 3'b000);

      // Drop and clear in the same cycle: overflow stays set.
      btn_in = 4'hF;
      tick(10);
      btn_in = 4'b0000;
      tick(10);
      btn_in = 4'hF;
      tick(10);
      btn_in = 4'b1011;
      tick(6);
`ifndef BTN_RELEASE_EVENTS_EN
      check("dropclr_pre", overflow, 1'b0);
`endif
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      check("dropclr_ovf",   overflow, 1'b1);
      check("dropclr_count", event_count, 3'd4);

      // Reset mid-debounce with events queued discards everything.
      btn_in = 4'hF;
      tick(10);
      btn_in = 4'b0111;
      tick(3);
      reset = 1'b1;
      btn_in = 4'hF;
      tick(2);
      reset = 1'b0;
      tick(12);
      check("rst2_count", event_count, 3'd0);
      check("rst2_valid", event_valid, 1'b0);
      check("rst2_state", btn_state, 4'b0000);
      check("rst2_ovf",   overflow, 1'b0);

      // Full FIFO, write and read in the same cycle: count unchanged.
      btn_in = 4'b0000;
      tick(10);
      btn_in = 4'hF;
      tick(10);
      btn_in = 4'b1101;
      tick(6);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("fullrw_count", event_count, 3'd4);
      check("fullrw_head",  event_data, 3'b101);
      drain();

`ifdef BTN_RELEASE_EVENTS_EN
      btn_in = 4'hF;
      tick(10);
      drain();
      btn_in = 4'b1101;
      tick(10);
      btn_in = 4'hF;
      tick(10);
      check("rel_count", event_count, 3'd2);
      check("rel_press", event_data, 3'b101);
      pop1();
      check("rel_release", event_data, 3'b001);
      drain();
`endif

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
